// File: rtl/booth_enc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | booth_enc_seq : sequential radix-4 Booth encoder, one control word per      |
// |                 two-bit group of the multiplier over valid/ready            |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module booth_enc_seq #(
  parameter int B_LEN = 64,
  parameter int IDX_W = $clog2(B_LEN/2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B_LEN-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_neg,
  output logic             out_zero,
  output logic             out_one,
  output logic             out_two,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int               GROUPS     = B_LEN / 2;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(GROUPS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Holds b[B_LEN-1:1]; the low three bits are always the next group's triplet,
  // so the bit just shifted out doubles as the previous-group bit.
  logic [B_LEN-2:0] r_sr;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_neg;
  logic             r_zero;
  logic             r_one;
  logic             r_two;
  logic             r_last;

  logic             w_load;
  logic             w_adv;
  logic             w_done;
  logic [3:0]       w_enc_load;
  logic [3:0]       w_enc_next;

  // Returns {neg, zero, one, two} for triplet {b[2i+1], b[2i], b[2i-1]}.
  function automatic logic [3:0] booth_enc(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: booth_enc = 4'b0010;
      3'b011:         booth_enc = 4'b0001;
      3'b100:         booth_enc = 4'b1001;
      3'b101, 3'b110: booth_enc = 4'b1010;
      default:        booth_enc = 4'b0100;
    endcase
  endfunction

  assign w_enc_load = booth_enc({in_b[1], in_b[0], 1'b0});
  assign w_enc_next = booth_enc(r_sr[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_valid && out_ready) begin
          if (r_idx == c_LAST_IDX) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b0;
      r_one   <= 1'b0;
      r_two   <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_sr                         <= in_b[B_LEN-1:1];
      r_idx                        <= '0;
      r_valid                      <= 1'b1;
      {r_neg, r_zero, r_one, r_two} <= w_enc_load;
      r_last                       <= 1'b0;
    end else if (w_adv) begin
      r_sr                         <= r_sr >> 2;
      r_idx                        <= r_idx + IDX_W'(1);
      {r_neg, r_zero, r_one, r_two} <= w_enc_next;
      r_last                       <= ((r_idx + IDX_W'(1)) == c_LAST_IDX);
    end else if (w_done) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign out_valid = r_valid;
  assign out_neg   = r_neg;
  assign out_zero  = r_zero;
  assign out_one   = r_one;
  assign out_two   = r_two;
  assign out_idx   = r_idx;
  assign out_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_booth_enc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_booth_enc_seq : self-checking bench for booth_enc_seq (B_LEN = 64)       |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_booth_enc_seq;

  localparam int B_LEN  = 64;
  localparam int IDX_W  = 5;
  localparam int GROUPS = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [B_LEN-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_neg;
  logic             out_zero;
  logic             out_one;
  logic             out_two;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  booth_enc_seq #(.B_LEN(B_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_neg(out_neg), .out_zero(out_zero), .out_one(out_one), .out_two(out_two),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic             neg;
    logic             zero;
    logic             one;
    logic             two;
    logic             last;
  } word_t;

  typedef struct {
    logic [63:0] b;
    logic [3:0]  e0;
    logic [3:0]  e1;
    logic [3:0]  e31;
  } vec_t;

  word_t       exp_q[$];
  logic [63:0] op_q[$];
  int          accept_cyc[$];
  logic [3:0]  obs[GROUPS];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  int hold = 0;
  bit rand_ready = 1'b0;
  bit stall5 = 1'b0;
  bit stalled = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Group value is -2*b[2i+1] + b[2i] + b[2i-1]; the word is derived from its sign/magnitude.
  function automatic word_t model(input logic [63:0] b, input int i);
    int    v;
    logic  pb;
    word_t w;
    pb = 1'b0;
    if (i > 0) pb = b[2*i-1];
    v = -2 * int'(b[2*i+1]) + int'(b[2*i]) + int'(pb);
    w.valid = 1'b1;
    w.idx   = IDX_W'(i);
    w.neg   = (v < 0);
    w.zero  = (v == 0);
    w.one   = (v == 1) || (v == -1);
    w.two   = (v == 2) || (v == -2);
    w.last  = (i == GROUPS - 1);
    return w;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  word_t              mon_cur;
  word_t              mon_prev;
  word_t              mon_exp;
  bit                 mon_stall = 1'b0;
  logic [63:0]        mon_b;
  logic signed [127:0] acc = '0;
  logic signed [127:0] term;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mon_stall = 1'b0;
    end else begin
      mon_cur = {out_valid, out_idx, out_neg, out_zero, out_one, out_two, out_last};
      if (mon_stall) check("stall_hold", 128'(mon_cur), 128'(mon_prev));
      if (in_valid && in_ready) begin
        for (int i = 0; i < GROUPS; i++) exp_q.push_back(model(in_b, i));
        op_q.push_back(in_b);
        accept_cyc.push_back(cyc);
        acc = '0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got idx %0d, required no word", out_idx);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 128'(mon_cur), 128'(mon_exp));
          obs[out_idx] = {out_neg, out_zero, out_one, out_two};
          term = 128'(out_two ? 2 : (out_one ? 1 : 0));
          term = term <<< (2 * int'(out_idx));
          if (out_neg) term = -term;
          acc = acc + term;
          if (out_last && op_q.size() > 0) begin
            mon_b = op_q.pop_front();
            check("weighted_sum", acc, {{64{mon_b[63]}}, mon_b});
          end
        end
      end
      mon_stall = out_valid && !out_ready;
      mon_prev  = mon_cur;
    end
  end

  // Downstream ready: steady, random, or a three-cycle stall when idx 5 appears.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else if (stall5 && !stalled && out_valid && out_idx == 5) begin
        out_ready = 1'b0;
        hold      = 2;
        stalled   = 1'b1;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [63:0] b, output int lat);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("accept_valid", 128'({out_valid, busy, in_ready, out_idx}), 128'({1'b1, 1'b1, 1'b0, 5'd0}));
    lat = 0;
    while (!in_ready && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(in_ready && exp_q.size() == 0) && n < 500);
    if (n >= 500) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: pending words %0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  vec_t vt[5];
  int   lat;
  int   n;

  initial begin
    vt[0] = '{64'h3,                   4'b1010, 4'b0010, 4'b0100};
    vt[1] = '{64'h2,                   4'b1001, 4'b0010, 4'b0100};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'b1010, 4'b0100, 4'b0100};
    vt[3] = '{64'h8000_0000_0000_0000, 4'b0100, 4'b0100, 4'b1001};
    vt[4] = '{64'h1,                   4'b0010, 4'b0100, 4'b0100};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", 128'({in_ready, busy, out_valid}), 128'(3'b100));
    check("reset_word", 128'({out_neg, out_zero, out_one, out_two, out_idx, out_last}), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      send(vt[v].b, lat);
      check("last_accept_edge", 128'(lat), 128'(GROUPS));
      check("queue_drained", 128'(exp_q.size()), 128'(0));
      check("grp0", 128'(obs[0]), 128'(vt[v].e0));
      check("grp1", 128'(obs[1]), 128'(vt[v].e1));
      check("grp31", 128'(obs[31]), 128'(vt[v].e31));
    end

    stall5  = 1'b1;
    stalled = 1'b0;
    send({$urandom, $urandom}, lat);
    stall5 = 1'b0;
    check("stall_latency", 128'(lat), 128'(GROUPS + 3));

    accept_cyc.delete();
    repeat (110) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_b     = {$urandom, $urandom};
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();
    check("accept_count", 128'(accept_cyc.size()), 128'(4));
    for (int i = 1; i < accept_cyc.size(); i++)
      check("spacing", 128'(accept_cyc[i] - accept_cyc[i-1]), 128'(GROUPS + 1));

    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_b     = {$urandom, $urandom};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_idx != 10 && n < 100);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 128'({out_valid, in_ready, busy, out_idx}), 128'({1'b0, 1'b1, 1'b0, 5'd0}));
    exp_q.delete();
    op_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 128'({out_valid, in_ready}), 128'(2'b01));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("no_words_after_reset", 128'(out_valid), 128'(0));
    for (int i = 0; i < GROUPS; i++) obs[i] = 4'b0000;
    send(64'h1, lat);
    check("post_reset_grp0", 128'(obs[0]), 128'(4'b0010));
    check("post_reset_grp1", 128'(obs[1]), 128'(4'b0100));
    check("post_reset_grp31", 128'(obs[31]), 128'(4'b0100));

    rand_ready = 1'b1;
    for (int k = 0; k < 1000; k++) send({$urandom, $urandom}, lat);
    rand_ready = 1'b0;
    wait_idle();
    check("final_queue", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
